// File: rtl/avalon_dmi_bridge.sv
// Avalon-MM slave to RISC-V DMI bridge with local control/status registers,
// byte-enable read-modify-write and a DMI response timeout with late-response drain.
module avalon_dmi_bridge #(
  parameter int AVL_ADDR_W     = 10,
  parameter int DMI_ADDR_W     = 7,
  parameter int NUM_CTRL_REGS  = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit RMW_EN         = 1'b1
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [AVL_ADDR_W-1:0]       avalon_s_address,
  input  logic [31:0]                 avalon_s_writedata,
  input  logic [3:0]                  avalon_s_byteenable,
  input  logic                        avalon_s_write,
  input  logic                        avalon_s_read,
  input  logic                        avalon_s_chipselect,
  output logic                        avalon_s_waitrequest_n,
  output logic [31:0]                 avalon_s_readdata,
  output logic [1:0]                  avalon_s_response,
  output logic                        avalon_s_readdatavalid,
  output logic                        avalon_s_writeresponsevalid,
  output logic                        dmi_req_valid_o,
  input  logic                        dmi_req_ready_i,
  output logic [DMI_ADDR_W-1:0]       dmi_req_addr_o,
  output logic [1:0]                  dmi_req_op_o,
  output logic [31:0]                 dmi_req_data_o,
  input  logic                        dmi_resp_valid_i,
  output logic                        dmi_resp_ready_o,
  input  logic [31:0]                 dmi_resp_data_i,
  input  logic [1:0]                  dmi_resp_resp_i,
  output logic [32*NUM_CTRL_REGS-1:0] ctrl_o
);

  // state      | meaning
  // S_IDLE     | ready for a new Avalon command (only state with waitrequest_n=1)
  // S_REQ      | DMI request presented (read, full write or merged RMW write)
  // S_WAIT     | waiting for the DMI response of S_REQ
  // S_RMW_REQ  | DMI read presented to fetch the word for a partial write
  // S_RMW_WAIT | waiting for the RMW read data, then merge
  // S_RESP     | one-cycle Avalon response pulse
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_RMW_REQ, S_RMW_WAIT, S_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] OP_RD       = 2'd1;
  localparam logic [1:0] OP_WR       = 2'd2;

  localparam int              LIDX_W   = AVL_ADDR_W - 3;
  localparam logic [LIDX_W-1:0] NCR    = LIDX_W'(NUM_CTRL_REGS);
  localparam int              TMR_W    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);

  state_t r_state, w_state_nx;

  logic [TMR_W-1:0]                r_tmr;
  logic                            r_is_wr;
  logic [31:0]                     r_wdata;
  logic [3:0]                      r_be;
  logic [DMI_ADDR_W-1:0]           r_req_addr;
  logic [1:0]                      r_req_op;
  logic [31:0]                     r_req_data;
  logic [31:0]                     r_rdata;
  logic [1:0]                      r_resp;
  logic                            r_st_tmo;
  logic                            r_st_derr;
  logic                            r_drain;
  logic [7:0]                      r_err_cnt;
  logic [NUM_CTRL_REGS-1:0][31:0]  r_ctrl;

  logic                w_cmd;
  logic                w_local;
  logic                w_dmi_dec_err;
  logic [LIDX_W-1:0]   w_lidx;
  logic                w_is_ctrl;
  logic                w_is_stat;
  logic                w_loc_err;
  logic                w_full_wr;
  logic                w_tmo;
  logic [31:0]         w_ctrl_rd;
  logic [31:0]         w_status;
  logic [31:0]         w_merged;
  logic                w_unused;

  logic                w_waitreq_n;
  logic                w_accept;
  logic                w_enter_resp;
  logic [1:0]          w_resp_code;
  logic                w_rdata_ld;
  logic [31:0]         w_rdata_nx;
  logic                w_tmo_hit;
  logic                w_drain_set;
  logic                w_dmi_err;
  logic                w_merge;
  logic                w_dmi_start;
  logic                w_ctrl_wr;
  logic                w_stat_wr;

  assign w_unused = ^avalon_s_address[1:0];

  assign w_cmd         = avalon_s_chipselect & (avalon_s_read | avalon_s_write);
  assign w_local       = avalon_s_address[AVL_ADDR_W-1];
  assign w_dmi_dec_err = ~w_local & (|(avalon_s_address[AVL_ADDR_W-2:0] >> (DMI_ADDR_W + 2)));
  assign w_lidx        = avalon_s_address[AVL_ADDR_W-2:2];
  assign w_is_ctrl     = w_local & (w_lidx < NCR);
  assign w_is_stat     = w_local & (w_lidx == NCR);
  assign w_loc_err     = w_local & ~w_is_ctrl & ~w_is_stat;
  assign w_full_wr     = avalon_s_write & (avalon_s_byteenable == 4'hF);
  assign w_tmo         = (TIMEOUT_CYCLES != 0) && (r_tmr == '0);

  assign w_status = {16'h0, r_err_cnt, 5'h0, r_drain, r_st_derr, r_st_tmo};

  always_comb begin
    w_ctrl_rd = '0;
    for (int k = 0; k < NUM_CTRL_REGS; k++) begin
      if (w_lidx == LIDX_W'(k)) w_ctrl_rd = r_ctrl[k];
    end
  end

  always_comb begin
    w_merged = '0;
    for (int b = 0; b < 4; b++) begin
      w_merged[8*b +: 8] = r_be[b] ? r_wdata[8*b +: 8] : dmi_resp_data_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_waitreq_n  = 1'b0;
    w_accept     = 1'b0;
    w_enter_resp = 1'b0;
    w_resp_code  = RESP_OKAY;
    w_rdata_ld   = 1'b0;
    w_rdata_nx   = '0;
    w_tmo_hit    = 1'b0;
    w_drain_set  = 1'b0;
    w_dmi_err    = 1'b0;
    w_merge      = 1'b0;
    w_dmi_start  = 1'b0;
    w_ctrl_wr    = 1'b0;
    w_stat_wr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        // DMI-window commands stall while a timed-out response is still owed
        w_waitreq_n = ~(r_drain & w_cmd & ~w_local);
        if (w_cmd && w_waitreq_n) begin
          w_accept = 1'b1;
          if (w_loc_err || w_dmi_dec_err) begin
            w_state_nx   = S_RESP;
            w_enter_resp = 1'b1;
            w_resp_code  = RESP_DECERR;
            w_rdata_ld   = ~avalon_s_write;
          end else if (w_local) begin
            w_state_nx   = S_RESP;
            w_enter_resp = 1'b1;
            if (!avalon_s_write) begin
              w_rdata_ld = 1'b1;
              w_rdata_nx = w_is_ctrl ? w_ctrl_rd : w_status;
            end else begin
              w_ctrl_wr = w_is_ctrl;
              w_stat_wr = w_is_stat;
            end
          end else if (!avalon_s_write || w_full_wr) begin
            w_state_nx  = S_REQ;
            w_dmi_start = 1'b1;
          end else if (avalon_s_byteenable == 4'h0) begin
            w_state_nx   = S_RESP;
            w_enter_resp = 1'b1;
          end else if (RMW_EN) begin
            w_state_nx  = S_RMW_REQ;
            w_dmi_start = 1'b1;
          end else begin
            w_state_nx   = S_RESP;
            w_enter_resp = 1'b1;
            w_resp_code  = RESP_SLVERR;
          end
        end
      end
      S_REQ, S_RMW_REQ: begin
        if (dmi_req_ready_i) begin
          w_state_nx = (r_state == S_REQ) ? S_WAIT : S_RMW_WAIT;
        end else if (w_tmo) begin
          w_state_nx   = S_RESP;
          w_enter_resp = 1'b1;
          w_resp_code  = RESP_SLVERR;
          w_tmo_hit    = 1'b1;
        end
      end
      S_WAIT: begin
        if (dmi_resp_valid_i) begin
          w_state_nx   = S_RESP;
          w_enter_resp = 1'b1;
          w_dmi_err    = (dmi_resp_resp_i != 2'd0);
          w_resp_code  = w_dmi_err ? RESP_SLVERR : RESP_OKAY;
          w_rdata_ld   = ~r_is_wr;
          w_rdata_nx   = dmi_resp_data_i;
        end else if (w_tmo) begin
          w_state_nx   = S_RESP;
          w_enter_resp = 1'b1;
          w_resp_code  = RESP_SLVERR;
          w_tmo_hit    = 1'b1;
          w_drain_set  = 1'b1;
        end
      end
      S_RMW_WAIT: begin
        if (dmi_resp_valid_i) begin
          if (dmi_resp_resp_i == 2'd0) begin
            w_state_nx = S_REQ;
            w_merge    = 1'b1;
          end else begin
            w_state_nx   = S_RESP;
            w_enter_resp = 1'b1;
            w_resp_code  = RESP_SLVERR;
            w_dmi_err    = 1'b1;
          end
        end else if (w_tmo) begin
          w_state_nx   = S_RESP;
          w_enter_resp = 1'b1;
          w_resp_code  = RESP_SLVERR;
          w_tmo_hit    = 1'b1;
          w_drain_set  = 1'b1;
        end
      end
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Timer reloads on every state change, so each REQ/WAIT phase gets a full budget
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       r_tmr <= '0;
    else if (w_state_nx != r_state)    r_tmr <= TMR_LOAD;
    else if (r_tmr != '0)              r_tmr <= r_tmr - TMR_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_is_wr    <= 1'b0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_req_addr <= '0;
      r_req_op   <= '0;
      r_req_data <= '0;
    end else begin
      if (w_accept) begin
        r_is_wr <= avalon_s_write;
        r_wdata <= avalon_s_writedata;
        r_be    <= avalon_s_byteenable;
      end
      if (w_dmi_start) begin
        r_req_addr <= avalon_s_address[DMI_ADDR_W+1:2];
        r_req_op   <= w_full_wr ? OP_WR : OP_RD;
        r_req_data <= w_full_wr ? avalon_s_writedata : '0;
      end else if (w_merge) begin
        r_req_op   <= OP_WR;
        r_req_data <= w_merged;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdata <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      if (w_enter_resp) r_resp  <= w_resp_code;
      if (w_rdata_ld)   r_rdata <= w_rdata_nx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_st_tmo  <= 1'b0;
      r_st_derr <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      if (w_stat_wr) begin
        if (avalon_s_byteenable[0] && avalon_s_writedata[0]) r_st_tmo  <= 1'b0;
        if (avalon_s_byteenable[0] && avalon_s_writedata[1]) r_st_derr <= 1'b0;
        if (avalon_s_byteenable[1] && avalon_s_writedata[8]) r_err_cnt <= '0;
      end
      if (w_tmo_hit) r_st_tmo  <= 1'b1;
      if (w_dmi_err) r_st_derr <= 1'b1;
      if (w_enter_resp && (w_resp_code != RESP_OKAY) && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Drain swallows exactly one late response after a WAIT-phase timeout
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                          r_drain <= 1'b0;
    else if (w_drain_set)                 r_drain <= 1'b1;
    else if (r_drain && dmi_resp_valid_i) r_drain <= 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ctrl <= '0;
    end else if (w_ctrl_wr) begin
      for (int k = 0; k < NUM_CTRL_REGS; k++) begin
        if (w_lidx == LIDX_W'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (avalon_s_byteenable[b]) r_ctrl[k][8*b +: 8] <= avalon_s_writedata[8*b +: 8];
          end
        end
      end
    end
  end

  assign avalon_s_waitrequest_n      = w_waitreq_n;
  assign avalon_s_readdata           = r_rdata;
  assign avalon_s_response           = r_resp;
  assign avalon_s_readdatavalid      = (r_state == S_RESP) & ~r_is_wr;
  assign avalon_s_writeresponsevalid = (r_state == S_RESP) & r_is_wr;
  assign dmi_req_valid_o             = (r_state == S_REQ) | (r_state == S_RMW_REQ);
  assign dmi_req_addr_o              = r_req_addr;
  assign dmi_req_op_o                = r_req_op;
  assign dmi_req_data_o              = r_req_data;
  assign dmi_resp_ready_o            = 1'b1;
  assign ctrl_o                      = r_ctrl;

endmodule

// File: tb/tb_avalon_dmi_bridge.sv
// Directed bench for avalon_dmi_bridge: local regs, DMI read, RMW, timeout/drain,
// error accounting and mid-transaction reset.
module tb_avalon_dmi_bridge;

  localparam int AW = 10;
  localparam int DW = 7;
  localparam int NC = 2;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [AW-1:0] avalon_s_address;
  logic [31:0]   avalon_s_writedata;
  logic [3:0]    avalon_s_byteenable;
  logic          avalon_s_write, avalon_s_read, avalon_s_chipselect;
  logic          avalon_s_waitrequest_n;
  logic [31:0]   avalon_s_readdata;
  logic [1:0]    avalon_s_response;
  logic          avalon_s_readdatavalid, avalon_s_writeresponsevalid;
  logic          dmi_req_valid_o, dmi_req_ready_i;
  logic [DW-1:0] dmi_req_addr_o;
  logic [1:0]    dmi_req_op_o;
  logic [31:0]   dmi_req_data_o;
  logic          dmi_resp_valid_i, dmi_resp_ready_o;
  logic [31:0]   dmi_resp_data_i;
  logic [1:0]    dmi_resp_resp_i;
  logic [32*NC-1:0] ctrl_o;

  int n_tests = 0;
  int n_fail  = 0;

  avalon_dmi_bridge #(
    .AVL_ADDR_W(AW), .DMI_ADDR_W(DW), .NUM_CTRL_REGS(NC),
    .TIMEOUT_CYCLES(16), .RMW_EN(1'b1)
  ) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .avalon_s_address(avalon_s_address), .avalon_s_writedata(avalon_s_writedata),
    .avalon_s_byteenable(avalon_s_byteenable), .avalon_s_write(avalon_s_write),
    .avalon_s_read(avalon_s_read), .avalon_s_chipselect(avalon_s_chipselect),
    .avalon_s_waitrequest_n(avalon_s_waitrequest_n), .avalon_s_readdata(avalon_s_readdata),
    .avalon_s_response(avalon_s_response), .avalon_s_readdatavalid(avalon_s_readdatavalid),
    .avalon_s_writeresponsevalid(avalon_s_writeresponsevalid),
    .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
    .dmi_req_addr_o(dmi_req_addr_o), .dmi_req_op_o(dmi_req_op_o),
    .dmi_req_data_o(dmi_req_data_o), .dmi_resp_valid_i(dmi_resp_valid_i),
    .dmi_resp_ready_o(dmi_resp_ready_o), .dmi_resp_data_i(dmi_resp_data_i),
    .dmi_resp_resp_i(dmi_resp_resp_i), .ctrl_o(ctrl_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] loc(input int i);
    return AW'(10'h200 | 10'(i * 4));
  endfunction

  function automatic logic [AW-1:0] dmi(input int a);
    return AW'(a * 4);
  endfunction

  // Drive a command, wait (bounded) for acceptance; returns one sample after the accept edge
  task automatic avl_issue(input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wd, input logic [3:0] be);
    int n;
    avalon_s_address    = addr;
    avalon_s_writedata  = wd;
    avalon_s_byteenable = be;
    avalon_s_write      = wr;
    avalon_s_read       = ~wr;
    avalon_s_chipselect = 1'b1;
    n = 0;
    while (avalon_s_waitrequest_n !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("accept_wait", 32'(avalon_s_waitrequest_n), 32'd1);
    tick();
    avalon_s_chipselect = 1'b0;
    avalon_s_write      = 1'b0;
    avalon_s_read       = 1'b0;
  endtask

  task automatic dmi_handshake();
    chk("req_valid", 32'(dmi_req_valid_o), 32'd1);
    dmi_req_ready_i = 1'b1;
    tick();
    dmi_req_ready_i = 1'b0;
  endtask

  task automatic dmi_respond(input logic [31:0] d, input logic [1:0] r);
    dmi_resp_valid_i = 1'b1;
    dmi_resp_data_i  = d;
    dmi_resp_resp_i  = r;
    tick();
    dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i  = '0;
    dmi_resp_resp_i  = '0;
  endtask

  initial begin
    int n;
    rst_ni = 1'b0;
    avalon_s_address = '0; avalon_s_writedata = '0; avalon_s_byteenable = '0;
    avalon_s_write = 1'b0; avalon_s_read = 1'b0; avalon_s_chipselect = 1'b0;
    dmi_req_ready_i = 1'b0; dmi_resp_valid_i = 1'b0;
    dmi_resp_data_i = '0; dmi_resp_resp_i = '0;
    repeat (3) @(posedge clk_i);
    #1;

    chk("rst_waitreq_n", 32'(avalon_s_waitrequest_n), 32'd1);
    chk("rst_rdv",       32'(avalon_s_readdatavalid), 32'd0);
    chk("rst_wrv",       32'(avalon_s_writeresponsevalid), 32'd0);
    chk("rst_req_valid", 32'(dmi_req_valid_o), 32'd0);
    chk("rst_readdata",  avalon_s_readdata, 32'd0);
    chk("rst_response",  32'(avalon_s_response), 32'd0);
    chk("rst_req_fields", {dmi_req_data_o[23:0], 1'b0, dmi_req_addr_o}, 32'd0);
    chk("rst_req_op",    32'(dmi_req_op_o), 32'd0);
    chk("rst_ctrl",      ctrl_o[31:0] | ctrl_o[63:32], 32'd0);
    chk("rst_resp_ready", 32'(dmi_resp_ready_o), 32'd1);
    rst_ni = 1'b1;
    tick();

    // ctrl reg 0 byte write, then readback
    avl_issue(1'b1, loc(0), 32'h000000A5, 4'h1);
    chk("ctrl_wr_pulse", 32'(avalon_s_writeresponsevalid), 32'd1);
    chk("ctrl_wr_resp",  32'(avalon_s_response), 32'd0);
    chk("resp_no_accept", 32'(avalon_s_waitrequest_n), 32'd0);
    tick();
    chk("ctrl_o_0",      ctrl_o[31:0], 32'h000000A5);
    chk("wr_pulse_1cyc", 32'(avalon_s_writeresponsevalid), 32'd0);
    avl_issue(1'b0, loc(0), 32'h0, 4'hF);
    chk("ctrl_rd_pulse", 32'(avalon_s_readdatavalid), 32'd1);
    chk("ctrl_rd_data",  avalon_s_readdata, 32'h000000A5);
    chk("ctrl_rd_resp",  32'(avalon_s_response), 32'd0);

    // DMI read, ready held low for 3 cycles
    avl_issue(1'b0, dmi(8'h11), 32'h0, 4'hF);
    for (int i = 0; i < 3; i++) begin
      chk("rd_valid_held", 32'(dmi_req_valid_o), 32'd1);
      chk("rd_addr_held",  32'(dmi_req_addr_o), 32'h11);
      chk("rd_op_held",    32'(dmi_req_op_o), 32'd1);
      tick();
    end
    dmi_handshake();
    chk("rd_valid_drop", 32'(dmi_req_valid_o), 32'd0);
    dmi_respond(32'hDEADBEEF, 2'd0);
    chk("rd_rdv",        32'(avalon_s_readdatavalid), 32'd1);
    chk("rd_data",       avalon_s_readdata, 32'hDEADBEEF);
    chk("rd_resp",       32'(avalon_s_response), 32'd0);
    tick();
    chk("rd_rdv_1cyc",   32'(avalon_s_readdatavalid), 32'd0);
    chk("rd_data_hold",  avalon_s_readdata, 32'hDEADBEEF);

    // partial write via read-modify-write
    avl_issue(1'b1, dmi(8'h04), 32'h00CC0000, 4'h4);
    chk("rmw_rd_op",     32'(dmi_req_op_o), 32'd1);
    chk("rmw_rd_addr",   32'(dmi_req_addr_o), 32'h04);
    dmi_handshake();
    dmi_respond(32'h11223344, 2'd0);
    chk("rmw_wr_op",     32'(dmi_req_op_o), 32'd2);
    chk("rmw_wr_data",   dmi_req_data_o, 32'h11CC3344);
    chk("rmw_wr_addr",   32'(dmi_req_addr_o), 32'h04);
    dmi_handshake();
    dmi_respond(32'h0, 2'd0);
    chk("rmw_wrv",       32'(avalon_s_writeresponsevalid), 32'd1);
    chk("rmw_resp",      32'(avalon_s_response), 32'd0);
    tick();

    // zero byte-enable DMI write: OKAY with no DMI traffic
    avl_issue(1'b1, dmi(8'h09), 32'hFFFFFFFF, 4'h0);
    chk("be0_no_req",    32'(dmi_req_valid_o), 32'd0);
    chk("be0_wrv",       32'(avalon_s_writeresponsevalid), 32'd1);
    chk("be0_resp",      32'(avalon_s_response), 32'd0);
    tick();

    // timeout in WAIT: terminal count after 16 cycles, pulse on the following one
    avl_issue(1'b0, dmi(8'h05), 32'h0, 4'hF);
    dmi_handshake();
    n = 0;
    while (avalon_s_readdatavalid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_latency",   32'(n), 32'd17);
    chk("tmo_resp",      32'(avalon_s_response), 32'd2);
    chk("tmo_valid_off", 32'(dmi_req_valid_o), 32'd0);
    avl_issue(1'b0, loc(NC), 32'h0, 4'hF);
    chk("tmo_status",    avalon_s_readdata, 32'h00000105);

    // DMI command stalls until the late response is consumed
    avalon_s_address = dmi(8'h07); avalon_s_byteenable = 4'hF;
    avalon_s_read = 1'b1; avalon_s_write = 1'b0; avalon_s_chipselect = 1'b1;
    repeat (3) tick();
    chk("drain_stall",   32'(avalon_s_waitrequest_n), 32'd0);
    chk("drain_no_req",  32'(dmi_req_valid_o), 32'd0);
    dmi_respond(32'h0BADF00D, 2'd0);
    chk("drain_release", 32'(avalon_s_waitrequest_n), 32'd1);
    tick();
    avalon_s_chipselect = 1'b0; avalon_s_read = 1'b0;
    chk("post_drain_addr", 32'(dmi_req_addr_o), 32'h07);
    dmi_handshake();
    dmi_respond(32'h12345678, 2'd0);
    chk("post_drain_rdv",  32'(avalon_s_readdatavalid), 32'd1);
    chk("post_drain_data", avalon_s_readdata, 32'h12345678);
    avl_issue(1'b0, loc(NC), 32'h0, 4'hF);
    chk("status_drained", avalon_s_readdata, 32'h00000101);
    avl_issue(1'b1, loc(NC), 32'h00000103, 4'hF);
    avl_issue(1'b0, loc(NC), 32'h0, 4'hF);
    chk("status_clr1",   avalon_s_readdata, 32'h00000000);

    // decode error then DMI error response
    avl_issue(1'b0, loc(0), 32'h0, 4'hF);
    chk("pre_dec_data",  avalon_s_readdata, 32'h000000A5);
    avl_issue(1'b0, loc(5), 32'h0, 4'hF);
    chk("dec_rdv",       32'(avalon_s_readdatavalid), 32'd1);
    chk("dec_resp",      32'(avalon_s_response), 32'd3);
    chk("dec_data",      avalon_s_readdata, 32'h0);
    avl_issue(1'b0, dmi(8'h20), 32'h0, 4'hF);
    dmi_handshake();
    dmi_respond(32'hCAFEF00D, 2'd2);
    chk("derr_rdv",      32'(avalon_s_readdatavalid), 32'd1);
    chk("derr_resp",     32'(avalon_s_response), 32'd2);
    avl_issue(1'b0, loc(NC), 32'h0, 4'hF);
    chk("status_err",    avalon_s_readdata, 32'h00000202);
    avl_issue(1'b1, loc(NC), 32'h00000103, 4'hF);
    avl_issue(1'b0, loc(NC), 32'h0, 4'hF);
    chk("status_clr2",   avalon_s_readdata, 32'h00000000);

    // reset in the middle of a DMI request
    tick();
    avl_issue(1'b0, dmi(8'h33), 32'h0, 4'hF);
    chk("pre_rst_valid", 32'(dmi_req_valid_o), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(dmi_req_valid_o), 32'd0);
    chk("mid_rst_addr",  32'(dmi_req_addr_o), 32'd0);
    chk("mid_rst_wrn",   32'(avalon_s_waitrequest_n), 32'd1);
    chk("mid_rst_ctrl",  ctrl_o[31:0], 32'd0);
    chk("mid_rst_rdata", avalon_s_readdata, 32'd0);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
